// File: rtl/key_event_scheduler.sv
// Merges one-shot key events into a single ordered command stream: edge detect,
// per-source pending bits, fixed-priority arbiter, small FIFO and X hold timer.
module key_event_scheduler #(
  parameter int DEPTH       = 4,
  parameter int LONG_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic                     clk,
  input  logic                     buttom_rst,
  input  logic                     sign_pos_A,
  input  logic                     sign_pos_S,
  input  logic                     sign_pos_W,
  input  logic                     sign_pos_D,
  input  logic                     sign_pos_X,
  input  logic                     sign_neg_X,
  input  logic                     cmd_ready,
  input  logic                     drop_clr,
  output logic                     cmd_valid,
  output logic [2:0]               cmd_code,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     x_held,
  output logic                     drop_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, HELD} xstate_e;

  // Source index order: A, S, W, D, X down, X up
  logic [5:0]       in_v, ev;
  logic [5:0]       prev_q;
  logic [5:0]       pend_q, pend_d;
  logic [5:0]       set_v, grant_v;
  xstate_e          state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_q, long_d;
  logic             xd_set, xu_set;
  logic             pop, push, push_ok, drop;
  logic [2:0]       push_code;
  logic [2:0]       mem_q [DEPTH];
  logic [2:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [2:0]       code_q, code_d;
  logic             flag_q, flag_d;

  assign in_v = {sign_neg_X, sign_pos_X, sign_pos_D, sign_pos_W, sign_pos_S, sign_pos_A};
  assign ev   = in_v & ~prev_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    long_d     = long_q;
    xd_set     = 1'b0;
    xu_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev[4]) begin
          xd_set     = 1'b1;
          hold_cnt_d = '0;
          state_d    = HELD;
        end
      end
      HELD: begin
        if (hold_cnt_q < LONG_C) hold_cnt_d = hold_cnt_q + 1'b1;
        // Classification uses the count as it stood when the release was sampled
        if (ev[5]) begin
          xu_set  = 1'b1;
          long_d  = (hold_cnt_q >= LONG_C);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop       = (count_q != '0) & cmd_ready;
    push_ok   = (count_q < DEPTH_C) | pop;
    grant_v   = '0;
    push_code = 3'd0;
    if (push_ok) begin
      if (pend_q[5]) begin
        grant_v[5] = 1'b1;
        push_code  = long_q ? 3'd7 : 3'd6;
      end else if (pend_q[4]) begin
        grant_v[4] = 1'b1;
        push_code  = 3'd5;
      end else if (pend_q[0]) begin
        grant_v[0] = 1'b1;
        push_code  = 3'd1;
      end else if (pend_q[1]) begin
        grant_v[1] = 1'b1;
        push_code  = 3'd2;
      end else if (pend_q[2]) begin
        grant_v[2] = 1'b1;
        push_code  = 3'd3;
      end else if (pend_q[3]) begin
        grant_v[3] = 1'b1;
        push_code  = 3'd4;
      end
    end
    push   = |grant_v;
    set_v  = {xu_set, xd_set, ev[3:0]};
    // A re-arriving event for the source just granted is a fresh event, not a merge
    pend_d = (pend_q & ~grant_v) | set_v;
    drop   = |(set_v & pend_q & ~grant_v);
    flag_d = drop | (flag_q & ~drop_clr);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Head is precomputed so cmd_code comes straight from a register
    code_d = (count_d != '0) ? mem_d[rd_ptr_d] : 3'd0;
  end

  always_ff @(posedge clk or posedge buttom_rst) begin
    if (buttom_rst) begin
      prev_q     <= '0;
      pend_q     <= '0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      code_q     <= 3'd0;
      flag_q     <= 1'b0;
    end else begin
      prev_q     <= in_v;
      pend_q     <= pend_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      long_q     <= long_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      code_q     <= code_d;
      flag_q     <= flag_d;
    end
  end

  assign cmd_valid  = (count_q != '0);
  assign cmd_code   = code_q;
  assign fifo_count = count_q;
  assign x_held     = (state_q == HELD);
  assign drop_flag  = flag_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench for key_event_scheduler: directed scenarios plus random
// traffic against a queue-based behavioural model of the command stream.
module tb_key_event_scheduler;
  localparam int DEPTH = 4;
  localparam int L     = 16;

  logic       clk = 1'b0;
  logic       buttom_rst = 1'b1;
  logic       sign_pos_A = 1'b0, sign_pos_S = 1'b0, sign_pos_W = 1'b0, sign_pos_D = 1'b0;
  logic       sign_pos_X = 1'b0, sign_neg_X = 1'b0;
  logic       cmd_ready = 1'b0, drop_clr = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [2:0] fifo_count;
  logic       x_held, drop_flag;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state: queue of codes, per-source pending flags, X press record
  int q[$];
  int popped[$];
  bit mPend[6];
  bit mPrev[6];
  bit mHeld, mLong, mFlag;
  int mCnt;

  always #5 clk = ~clk;

  key_event_scheduler #(.DEPTH(DEPTH), .LONG_CYCLES(L), .CNT_W(5)) dut (
    .clk(clk), .buttom_rst(buttom_rst),
    .sign_pos_A(sign_pos_A), .sign_pos_S(sign_pos_S), .sign_pos_W(sign_pos_W),
    .sign_pos_D(sign_pos_D), .sign_pos_X(sign_pos_X), .sign_neg_X(sign_neg_X),
    .cmd_ready(cmd_ready), .drop_clr(drop_clr),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .fifo_count(fifo_count),
    .x_held(x_held), .drop_flag(drop_flag)
  );

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < 6; i++) begin
      mPend[i] = 1'b0;
      mPrev[i] = 1'b0;
    end
    mHeld = 1'b0;
    mLong = 1'b0;
    mFlag = 1'b0;
    mCnt  = 0;
  endfunction

  // One clock edge of the reference behaviour, from the rules of the command stream
  function automatic void model_edge();
    bit inV[6];
    bit ev[6];
    bit setV[6];
    int pri[6] = '{5, 4, 0, 1, 2, 3};
    int g;
    bit doPop, pushOk, drop;
    if (buttom_rst) begin
      model_reset();
      return;
    end
    inV = '{sign_pos_A, sign_pos_S, sign_pos_W, sign_pos_D, sign_pos_X, sign_neg_X};
    for (int i = 0; i < 6; i++) begin
      ev[i]    = inV[i] && !mPrev[i];
      mPrev[i] = inV[i];
      setV[i]  = (i < 4) ? ev[i] : 1'b0;
    end
    setV[4] = ev[4] && !mHeld;
    setV[5] = ev[5] && mHeld;
    doPop   = (q.size() != 0) && cmd_ready;
    pushOk  = (q.size() < DEPTH) || doPop;
    g = -1;
    if (pushOk)
      for (int j = 0; j < 6; j++)
        if (g < 0 && mPend[pri[j]]) g = pri[j];
    if (doPop) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back(g == 5 ? (mLong ? 7 : 6) : g + 1);
      mPend[g] = 1'b0;
    end
    drop = 1'b0;
    for (int i = 0; i < 6; i++)
      if (setV[i]) begin
        if (mPend[i]) drop = 1'b1;
        mPend[i] = 1'b1;
      end
    if (!mHeld) begin
      if (ev[4]) begin
        mHeld = 1'b1;
        mCnt  = 0;
      end
    end else begin
      if (ev[5]) begin
        mLong = (mCnt >= L);
        mHeld = 1'b0;
      end
      if (mCnt < L) mCnt++;
    end
    if (drop) mFlag = 1'b1;
    else if (drop_clr) mFlag = 1'b0;
  endfunction

  task automatic step();
    if (cmd_valid && cmd_ready) popped.push_back(int'(cmd_code));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", cmd_valid); end
    vectors++; if (cmd_code !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_code: got %0d expected 0", cmd_code); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
    vectors++; if (x_held !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_xheld: got %b expected 0", x_held); end
    vectors++; if (drop_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_drop: got %b expected 0", drop_flag); end
    buttom_rst = 1'b0;
    step();
  endtask

  task automatic test_single_press();
    int validCycles;
    cmd_ready  = 1'b1;
    sign_pos_A = 1'b1;
    step();
    sign_pos_A = 1'b0;
    vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_lat0: got %b expected 0", cmd_valid); end
    step();
    vectors++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin miscompares++; $display("[TB] FAIL single_out: got v=%b c=%0d expected v=1 c=1", cmd_valid, cmd_code); end
    step();
    vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_once: got %b expected 0", cmd_valid); end
    validCycles = 0;
    sign_pos_A = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (cmd_valid) validCycles++;
    end
    sign_pos_A = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cmd_valid) validCycles++;
    end
    vectors++; if (validCycles != 1) begin miscompares++; $display("[TB] FAIL single_held: got %0d commands expected 1", validCycles); end
  endtask

  task automatic test_simultaneous();
    cmd_ready = 1'b0;
    {sign_pos_A, sign_pos_S, sign_pos_W, sign_pos_D} = 4'hF;
    step();
    {sign_pos_A, sign_pos_S, sign_pos_W, sign_pos_D} = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++; if (fifo_count !== 3'(i + 1)) begin miscompares++; $display("[TB] FAIL simul_count: got %0d expected %0d", fifo_count, i + 1); end
    end
    popped.delete();
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    vectors++; if (popped.size() != 4) begin miscompares++; $display("[TB] FAIL simul_npop: got %0d expected 4", popped.size()); end
    for (int i = 0; i < popped.size() && i < 4; i++) begin
      vectors++; if (popped[i] != i + 1) begin miscompares++; $display("[TB] FAIL simul_order: got %0d expected %0d", popped[i], i + 1); end
    end
    vectors++; if (drop_flag !== 1'b0 || fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL simul_end: got drop=%b cnt=%0d expected 0 0", drop_flag, fifo_count); end
  endtask

  task automatic test_full_fifo();
    int expCodes[6] = '{1, 2, 3, 4, 4, 4};
    cmd_ready = 1'b0;
    {sign_pos_A, sign_pos_S, sign_pos_W, sign_pos_D} = 4'hF;
    step();
    {sign_pos_A, sign_pos_S, sign_pos_W, sign_pos_D} = 4'h0;
    for (int i = 0; i < 4; i++) step();
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("[TB] FAIL full_fill: got %0d expected 4", fifo_count); end
    sign_pos_D = 1'b1;
    step();
    sign_pos_D = 1'b0;
    step();
    step();
    vectors++; if (fifo_count !== 3'd4 || drop_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL full_hold: got cnt=%0d drop=%b expected 4 0", fifo_count, drop_flag); end
    popped.delete();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("[TB] FAIL full_poppush: got %0d expected 4", fifo_count); end
    sign_pos_D = 1'b1;
    step();
    sign_pos_D = 1'b0;
    step();
    sign_pos_D = 1'b1;
    step();
    sign_pos_D = 1'b0;
    vectors++; if (drop_flag !== 1'b1) begin miscompares++; $display("[TB] FAIL full_drop: got %b expected 1", drop_flag); end
    step();
    vectors++; if (drop_flag !== 1'b1) begin miscompares++; $display("[TB] FAIL full_sticky: got %b expected 1", drop_flag); end
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    vectors++; if (drop_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL full_clr: got %b expected 0", drop_flag); end
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    vectors++; if (popped.size() != 6) begin miscompares++; $display("[TB] FAIL full_npop: got %0d expected 6", popped.size()); end
    for (int i = 0; i < popped.size() && i < 6; i++) begin
      vectors++; if (popped[i] != expCodes[i]) begin miscompares++; $display("[TB] FAIL full_order[%0d]: got %0d expected %0d", i, popped[i], expCodes[i]); end
    end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL full_drain: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_x_short_long();
    int heldCycles;
    cmd_ready = 1'b1;
    popped.delete();
    heldCycles = 0;
    sign_pos_X = 1'b1;
    step();
    sign_pos_X = 1'b0;
    if (x_held) heldCycles++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (x_held) heldCycles++;
    end
    sign_neg_X = 1'b1;
    step();
    sign_neg_X = 1'b0;
    if (x_held) heldCycles++;
    for (int i = 0; i < 4; i++) step();
    vectors++; if (heldCycles != 5) begin miscompares++; $display("[TB] FAIL x_held_len: got %0d expected 5", heldCycles); end
    vectors++; if (popped.size() != 2 || popped[0] != 5 || popped[1] != 6) begin miscompares++; $display("[TB] FAIL x_short: got n=%0d codes %p expected 5 6", popped.size(), popped); end
    popped.delete();
    sign_pos_X = 1'b1;
    step();
    sign_pos_X = 1'b0;
    for (int i = 0; i < 39; i++) step();
    vectors++; if (dut.hold_cnt_q !== 5'(L) || mCnt != L) begin miscompares++; $display("[TB] FAIL x_sat: got %0d expected %0d", dut.hold_cnt_q, L); end
    sign_neg_X = 1'b1;
    step();
    sign_neg_X = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vectors++; if (popped.size() != 2 || popped[0] != 5 || popped[1] != 7) begin miscompares++; $display("[TB] FAIL x_long: got n=%0d codes %p expected 5 7", popped.size(), popped); end
  endtask

  task automatic test_spurious_x();
    cmd_ready = 1'b1;
    popped.delete();
    sign_neg_X = 1'b1;
    step();
    sign_neg_X = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vectors++; if (popped.size() != 0 || x_held !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_neg: got n=%0d held=%b expected 0 0", popped.size(), x_held); end
    sign_pos_X = 1'b1;
    sign_neg_X = 1'b1;
    step();
    sign_pos_X = 1'b0;
    sign_neg_X = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vectors++; if (popped.size() != 1 || popped[0] != 5 || x_held !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_same: got n=%0d codes %p held=%b expected one 5 held 1", popped.size(), popped, x_held); end
    sign_neg_X = 1'b1;
    step();
    sign_neg_X = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vectors++; if (popped.size() != 2 || popped[1] != 6) begin miscompares++; $display("[TB] FAIL spur_release: got n=%0d codes %p expected 5 6", popped.size(), popped); end
  endtask

  task automatic test_reset_mid();
    cmd_ready = 1'b0;
    popped.delete();
    sign_pos_X = 1'b1;
    sign_pos_A = 1'b1;
    sign_pos_S = 1'b1;
    step();
    sign_pos_X = 1'b0;
    sign_pos_A = 1'b0;
    sign_pos_S = 1'b0;
    for (int i = 0; i < 3; i++) step();
    vectors++; if (fifo_count !== 3'd3 || x_held !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pre: got cnt=%0d held=%b expected 3 1", fifo_count, x_held); end
    #3;
    buttom_rst = 1'b1;
    #1;
    vectors++; if ({cmd_valid, cmd_code, fifo_count, x_held, drop_flag} !== 9'd0) begin miscompares++; $display("[TB] FAIL rst_async: got v=%b c=%0d n=%0d h=%b d=%b expected all 0", cmd_valid, cmd_code, fifo_count, x_held, drop_flag); end
    step();
    buttom_rst = 1'b0;
    cmd_ready  = 1'b1;
    sign_neg_X = 1'b1;
    step();
    sign_neg_X = 1'b0;
    for (int i = 0; i < 5; i++) step();
    vectors++; if (popped.size() != 0 || cmd_valid !== 1'b0 || x_held !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_lost: got n=%0d v=%b h=%b expected 0 0 0", popped.size(), cmd_valid, x_held); end
  endtask

  task automatic test_random();
    int expCode;
    for (int i = 0; i < 400; i++) begin
      sign_pos_A = ($urandom_range(0, 3) == 0);
      sign_pos_S = ($urandom_range(0, 3) == 0);
      sign_pos_W = ($urandom_range(0, 3) == 0);
      sign_pos_D = ($urandom_range(0, 3) == 0);
      sign_pos_X = ($urandom_range(0, 7) == 0);
      sign_neg_X = ($urandom_range(0, 15) == 0);
      cmd_ready  = ($urandom_range(0, 1) == 0);
      drop_clr   = ($urandom_range(0, 7) == 0);
      step();
      expCode = (q.size() != 0) ? q[0] : 0;
      vectors++; if (cmd_valid !== (q.size() != 0)) begin miscompares++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", i, cmd_valid, q.size() != 0); end
      vectors++; if (cmd_code !== 3'(expCode)) begin miscompares++; $display("[TB] FAIL rnd_code@%0d: got %0d expected %0d", i, cmd_code, expCode); end
      vectors++; if (fifo_count !== 3'(q.size())) begin miscompares++; $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", i, fifo_count, q.size()); end
      vectors++; if (x_held !== mHeld) begin miscompares++; $display("[TB] FAIL rnd_xheld@%0d: got %b expected %b", i, x_held, mHeld); end
      vectors++; if (drop_flag !== mFlag) begin miscompares++; $display("[TB] FAIL rnd_drop@%0d: got %b expected %b", i, drop_flag, mFlag); end
    end
    {sign_pos_A, sign_pos_S, sign_pos_W, sign_pos_D, sign_pos_X, sign_neg_X, drop_clr} = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_simultaneous();
    test_full_fifo();
    test_x_short_long();
    test_spurious_x();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
